// File: rtl/instruction_fetch_queue_if.sv
// Fetch-side bus bundle: the request/response channel to the 1-cycle
// instruction memory and the valid/ready channel towards decode.
// master = the fetch queue, slave = the memory/decode environment.
interface instruction_fetch_queue_if #(
    parameter int len   = 32,
    parameter int DEPTH = 4
);
    localparam int OCC_W = $clog2(DEPTH) + 1;

    // Memory channel
    logic             out_mem_req;
    logic [len-1:0]   out_mem_addr;
    logic             in_mem_valid;
    logic [len-1:0]   in_mem_data;

    // Decode channel
    logic             out_valid;
    logic             in_ready;
    logic [len-1:0]   out_instruction;
    logic [len-1:0]   out_pc_branch;
    logic [OCC_W-1:0] out_occupancy;

    modport master (
        output out_mem_req,
        output out_mem_addr,
        input  in_mem_valid,
        input  in_mem_data,
        output out_valid,
        input  in_ready,
        output out_instruction,
        output out_pc_branch,
        output out_occupancy
    );

    modport slave (
        input  out_mem_req,
        input  out_mem_addr,
        output in_mem_valid,
        output in_mem_data,
        input  out_valid,
        output in_ready,
        input  out_instruction,
        input  out_pc_branch,
        input  out_occupancy
    );
endinterface

// File: rtl/instruction_fetch_queue.sv
// MIPS fetch stage: PC register with prioritised redirects, credit-limited
// pipelined requests to a 1-cycle instruction memory, and a DEPTH-entry
// prefetch FIFO delivering {instruction, PC+4} to decode over valid/ready.
// A redirect or reset flushes the FIFO and drops any response in flight.
module instruction_fetch_queue #(
    parameter int             len      = 32,
    parameter int             DEPTH    = 4,
    parameter logic [len-1:0] RESET_PC = '0
) (
    input  logic           clk,
    input  logic           reset,          // synchronous, active-low
    input  logic [2:0]     in_pc_src,      // [0] jump, [1] branch, [2] register
    input  logic [len-1:0] in_pc_jump,
    input  logic [len-1:0] in_pc_branch,
    input  logic [len-1:0] in_pc_register,
    input  logic           in_pc_enable,
    instruction_fetch_queue_if.master fq
);
    localparam int             PTR_W       = $clog2(DEPTH);
    localparam int             OCC_W       = PTR_W + 1;
    localparam logic [len-1:0] INSTR_BYTES = len'(4);

    // Architectural fetch state
    logic [len-1:0]   pc_q, pc_d;
    logic             inflight_q, inflight_d;
    logic [len-1:0]   inflight_addr_q, inflight_addr_d;

    // FIFO bookkeeping
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0] count_q, count_d;

    // FIFO storage: instruction word and its PC+4
    logic [len-1:0]   instr_mem [DEPTH];
    logic [len-1:0]   pc4_mem   [DEPTH];

    logic             redirect;
    logic [len-1:0]   redirect_target;
    logic             has_credit;
    logic             issue;
    logic             push;
    logic             pop;
    logic             head_valid;

    assign redirect = |in_pc_src;

    // Redirect target: register outranks branch, branch outranks jump
    always_comb begin
        // NOTE: every signal driven in always_comb gets a default first so no path leaves it unassigned (no latch).
        redirect_target = in_pc_jump;
        if (in_pc_src[2]) begin
            redirect_target = in_pc_register;
        end else if (in_pc_src[1]) begin
            redirect_target = in_pc_branch;
        end
    end

    // Credit covers stored entries plus the one response that may still arrive,
    // so a push can never find the FIFO full. A same-cycle pop adds no credit.
    assign has_credit = ({1'b0, count_q} + {{OCC_W{1'b0}}, inflight_q})
                        < (OCC_W + 1)'(DEPTH);

    assign issue      = reset && in_pc_enable && !redirect && has_credit;
    // A response landing in a redirect cycle belongs to the old stream: drop it.
    assign push       = reset && inflight_q && fq.in_mem_valid && !redirect;
    assign head_valid = reset && (count_q != '0);
    assign pop        = head_valid && fq.in_ready;

    // Next-state for PC, in-flight tracking and FIFO pointers/count
    always_comb begin
        pc_d            = pc_q;
        inflight_d      = issue;   // a redirect suppresses issue, which squashes the next response
        inflight_addr_d = inflight_addr_q;
        wr_ptr_d        = wr_ptr_q;
        rd_ptr_d        = rd_ptr_q;
        count_d         = count_q;

        if (redirect) begin
            pc_d     = redirect_target;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (issue) begin
                pc_d            = pc_q + INSTR_BYTES;
                inflight_addr_d = pc_q;
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + OCC_W'(1);
                2'b01:   count_d = count_q - OCC_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control register bank with synchronous active-low reset
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!reset) begin
            pc_q            <= RESET_PC;
            inflight_q      <= 1'b0;
            inflight_addr_q <= '0;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            count_q         <= '0;
        end else begin
            pc_q            <= pc_d;
            inflight_q      <= inflight_d;
            inflight_addr_q <= inflight_addr_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            count_q         <= count_d;
        end
    end

    // FIFO storage write: record the response word with its fall-through PC
    always_ff @(posedge clk) begin
        // NOTE: storage is deliberately not reset; count_q alone decides which entries are meaningful.
        if (push) begin
            instr_mem[wr_ptr_q] <= fq.in_mem_data;
            pc4_mem[wr_ptr_q]   <= inflight_addr_q + INSTR_BYTES;
        end
    end

    assign fq.out_mem_req     = issue;
    assign fq.out_mem_addr    = pc_q;
    assign fq.out_valid       = head_valid;
    assign fq.out_instruction = instr_mem[rd_ptr_q];
    assign fq.out_pc_branch   = pc4_mem[rd_ptr_q];
    assign fq.out_occupancy   = reset ? count_q : '0;

endmodule

// File: tb/tb_instruction_fetch_queue.sv
// Bench for instruction_fetch_queue: a directed vector table, hand-written
// redirect/reset sequences, and a randomized run against a queue-based model.
// A second instance with RESET_PC near the top of memory covers PC wrap.
module tb_instruction_fetch_queue;
    localparam int          LEN   = 32;
    localparam int          DEPTH = 4;
    localparam logic [31:0] RPC2  = 32'hFFFF_FFF8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  src = 3'b000;
    logic [31:0] tgt_jump = '0, tgt_branch = '0, tgt_reg = '0;
    logic        en = 1'b1;
    logic        ready = 1'b0;

    always #5 clk = ~clk;

    instruction_fetch_queue_if #(.len(LEN), .DEPTH(DEPTH)) bus  ();
    instruction_fetch_queue_if #(.len(LEN), .DEPTH(DEPTH)) bus2 ();

    instruction_fetch_queue #(.len(LEN), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
        .clk(clk), .reset(rst_n), .in_pc_src(src), .in_pc_jump(tgt_jump),
        .in_pc_branch(tgt_branch), .in_pc_register(tgt_reg), .in_pc_enable(en),
        .fq(bus.master)
    );

    instruction_fetch_queue #(.len(LEN), .DEPTH(DEPTH), .RESET_PC(RPC2)) dut2 (
        .clk(clk), .reset(rst_n), .in_pc_src(src), .in_pc_jump(tgt_jump),
        .in_pc_branch(tgt_branch), .in_pc_register(tgt_reg), .in_pc_enable(en),
        .fq(bus2.master)
    );

    assign bus.in_ready  = ready;
    assign bus2.in_ready = ready;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- memory stand-in ----------------
    logic [31:0] mem_salt = '0;
    logic        prev_req = 1'b0, prev_req2 = 1'b0;
    logic [31:0] prev_addr = '0, prev_addr2 = '0;

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return (addr >> 2) ^ mem_salt;
    endfunction

    // ---------------- sampled outputs ----------------
    logic        s_req, s_valid, s2_req, s2_valid;
    logic [31:0] s_addr, s_instr, s_pc4, s_occ, s2_addr, s2_pc4;

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc4;
    } entry_t;

    entry_t      q[$];
    logic [31:0] m_pc = '0;
    logic        m_infl = 1'b0;
    logic [31:0] m_infl_addr = '0;
    logic        e_req, e_valid;

    task automatic model_check();
        e_valid = rst_n && (q.size() > 0);
        e_req   = rst_n && en && (src == 3'b000) && ((q.size() + int'(m_infl)) < DEPTH);
        check("model_req", {31'b0, s_req}, {31'b0, e_req});
        check("model_valid", {31'b0, s_valid}, {31'b0, e_valid});
        check("model_occ", s_occ, rst_n ? q.size() : 0);
        if (e_req) check("model_addr", s_addr, m_pc);
        if (e_valid) begin
            check("model_instr", s_instr, q[0].instr);
            check("model_pc4", s_pc4, q[0].pc4);
        end
    endtask

    task automatic model_update();
        if (!rst_n) begin
            m_pc   = 32'h0;
            m_infl = 1'b0;
            q.delete();
        end else if (src != 3'b000) begin
            m_pc   = src[2] ? tgt_reg : (src[1] ? tgt_branch : tgt_jump);
            m_infl = 1'b0;
            q.delete();
        end else begin
            if (e_valid && ready) void'(q.pop_front());
            if (m_infl && bus.in_mem_valid) q.push_back('{bus.in_mem_data, m_infl_addr + 32'd4});
            if (e_req) begin
                m_infl_addr = m_pc;
                m_pc        = m_pc + 32'd4;
            end
            m_infl = e_req;
        end
    endtask

    // Drive memory responses, let logic settle, sample outputs, check the model.
    task automatic settle();
        bus.in_mem_valid  = prev_req;
        bus.in_mem_data   = mem_word(prev_addr);
        bus2.in_mem_valid = prev_req2;
        bus2.in_mem_data  = mem_word(prev_addr2);
        #1;
        s_req    = bus.out_mem_req;
        s_addr   = bus.out_mem_addr;
        s_valid  = bus.out_valid;
        s_instr  = bus.out_instruction;
        s_pc4    = bus.out_pc_branch;
        s_occ    = 32'(bus.out_occupancy);
        s2_req   = bus2.out_mem_req;
        s2_addr  = bus2.out_mem_addr;
        s2_valid = bus2.out_valid;
        s2_pc4   = bus2.out_pc_branch;
        model_check();
    endtask

    // Cross the active edge, update the model, return on the falling edge.
    task automatic advance();
        @(posedge clk);
        model_update();
        prev_req   = s_req;
        prev_addr  = s_addr;
        prev_req2  = s2_req;
        prev_addr2 = s2_addr;
        @(negedge clk);
    endtask

    task automatic cyc();
        settle();
        advance();
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        rst_n;
        logic        ready;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_instr;
        logic [31:0] exp_pc4;
        logic [31:0] exp_occ;
        int          chk2;       // 1: check wrap-instance address, 2: also its head
        logic [31:0] exp2_addr;
        logic [31:0] exp2_pc4;
    } vec_t;

    localparam int NV = 19;
    vec_t vecs[NV];

    initial begin
        // stream after reset, ready=1; wrap instance alongside
        vecs[0]  = '{0, 1, 0, 32'd0,  0, 32'd0, 32'd0,  32'd0, 0, 32'd0, 32'd0};
        vecs[1]  = '{1, 1, 1, 32'd0,  0, 32'd0, 32'd0,  32'd0, 1, 32'hFFFF_FFF8, 32'd0};
        vecs[2]  = '{1, 1, 1, 32'd4,  0, 32'd0, 32'd0,  32'd0, 1, 32'hFFFF_FFFC, 32'd0};
        vecs[3]  = '{1, 1, 1, 32'd8,  1, 32'd0, 32'd4,  32'd1, 2, 32'd0, 32'hFFFF_FFFC};
        vecs[4]  = '{1, 1, 1, 32'd12, 1, 32'd1, 32'd8,  32'd1, 2, 32'd4, 32'd0};
        vecs[5]  = '{1, 1, 1, 32'd16, 1, 32'd2, 32'd12, 32'd1, 2, 32'd8, 32'd4};
        // reset again, then fill with ready=0 until credit runs out
        vecs[6]  = '{0, 0, 0, 32'd0,  0, 32'd0, 32'd0,  32'd0, 0, 32'd0, 32'd0};
        vecs[7]  = '{1, 0, 1, 32'd0,  0, 32'd0, 32'd0,  32'd0, 0, 32'd0, 32'd0};
        vecs[8]  = '{1, 0, 1, 32'd4,  0, 32'd0, 32'd0,  32'd0, 0, 32'd0, 32'd0};
        vecs[9]  = '{1, 0, 1, 32'd8,  1, 32'd0, 32'd4,  32'd1, 0, 32'd0, 32'd0};
        vecs[10] = '{1, 0, 1, 32'd12, 1, 32'd0, 32'd4,  32'd2, 0, 32'd0, 32'd0};
        vecs[11] = '{1, 0, 0, 32'd0,  1, 32'd0, 32'd4,  32'd3, 0, 32'd0, 32'd0};
        vecs[12] = '{1, 0, 0, 32'd0,  1, 32'd0, 32'd4,  32'd4, 0, 32'd0, 32'd0};
        vecs[13] = '{1, 0, 0, 32'd0,  1, 32'd0, 32'd4,  32'd4, 0, 32'd0, 32'd0};
        // raise ready: pops drain, issue resumes at 16
        vecs[14] = '{1, 1, 0, 32'd0,  1, 32'd0, 32'd4,  32'd4, 0, 32'd0, 32'd0};
        vecs[15] = '{1, 1, 1, 32'd16, 1, 32'd1, 32'd8,  32'd3, 0, 32'd0, 32'd0};
        vecs[16] = '{1, 1, 1, 32'd20, 1, 32'd2, 32'd12, 32'd2, 0, 32'd0, 32'd0};
        vecs[17] = '{1, 1, 1, 32'd24, 1, 32'd3, 32'd16, 32'd2, 0, 32'd0, 32'd0};
        vecs[18] = '{1, 1, 1, 32'd28, 1, 32'd4, 32'd20, 32'd2, 0, 32'd0, 32'd0};

        bus.in_mem_valid  = 1'b0;
        bus.in_mem_data   = '0;
        bus2.in_mem_valid = 1'b0;
        bus2.in_mem_data  = '0;
        @(negedge clk);

        for (int i = 0; i < NV; i++) begin
            rst_n = vecs[i].rst_n;
            ready = vecs[i].ready;
            src   = 3'b000;
            en    = 1'b1;
            settle();
            check($sformatf("v%0d_req", i), {31'b0, s_req}, {31'b0, vecs[i].exp_req});
            if (vecs[i].exp_req) check($sformatf("v%0d_addr", i), s_addr, vecs[i].exp_addr);
            check($sformatf("v%0d_valid", i), {31'b0, s_valid}, {31'b0, vecs[i].exp_valid});
            if (vecs[i].exp_valid) begin
                check($sformatf("v%0d_instr", i), s_instr, vecs[i].exp_instr);
                check($sformatf("v%0d_pc4", i), s_pc4, vecs[i].exp_pc4);
            end
            check($sformatf("v%0d_occ", i), s_occ, vecs[i].exp_occ);
            if (vecs[i].chk2 >= 1) check($sformatf("v%0d_wrap_addr", i), s2_addr, vecs[i].exp2_addr);
            if (vecs[i].chk2 == 2) begin
                check($sformatf("v%0d_wrap_valid", i), {31'b0, s2_valid}, 32'd1);
                check($sformatf("v%0d_wrap_pc4", i), s2_pc4, vecs[i].exp2_pc4);
            end
            advance();
        end

        // ---- redirect via branch with a full FIFO ----
        ready = 1'b0;
        repeat (8) cyc();
        src = 3'b010; tgt_branch = 32'h100;
        settle();
        check("br_full_occ", s_occ, 32'd4);
        check("br_req_in_redirect", {31'b0, s_req}, 32'd0);
        advance();
        src = 3'b000;
        settle();
        check("br_flush_occ", s_occ, 32'd0);
        check("br_flush_valid", {31'b0, s_valid}, 32'd0);
        check("br_new_addr", s_addr, 32'h100);
        advance();
        settle();
        check("br_t2_valid", {31'b0, s_valid}, 32'd0);
        advance();
        settle();
        check("br_t3_valid", {31'b0, s_valid}, 32'd1);
        check("br_t3_pc4", s_pc4, 32'h104);
        check("br_t3_instr", s_instr, 32'h40);
        advance();

        // ---- all redirect bits set: register target wins ----
        src = 3'b111; tgt_reg = 32'h200; tgt_branch = 32'h300; tgt_jump = 32'h400;
        cyc();
        src = 3'b000;
        settle();
        check("prio_addr", s_addr, 32'h200);
        check("prio_req", {31'b0, s_req}, 32'd1);
        advance();

        // ---- one-cycle reset mid-stream with a response in flight ----
        ready = 1'b0;
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        repeat (4) cyc();
        rst_n = 1'b0;
        settle();
        check("rst_mid_infl_expected", {31'b0, s_occ == 32'd3 || s_occ == 32'd0}, 32'd1);
        check("rst_mid_valid", {31'b0, s_valid}, 32'd0);
        check("rst_mid_occ", s_occ, 32'd0);
        check("rst_mid_req", {31'b0, s_req}, 32'd0);
        check("rst_mid_stale_rsp", {31'b0, bus.in_mem_valid}, 32'd1);
        advance();
        rst_n = 1'b1;
        settle();
        check("rst_after_occ", s_occ, 32'd0);
        check("rst_after_valid", {31'b0, s_valid}, 32'd0);
        check("rst_after_addr", s_addr, 32'h0);
        advance();
        settle();
        check("rst_after2_valid", {31'b0, s_valid}, 32'd0);
        advance();
        settle();
        check("rst_after3_valid", {31'b0, s_valid}, 32'd1);
        check("rst_after3_pc4", s_pc4, 32'd4);
        check("rst_after3_instr", s_instr, 32'd0);
        advance();

        // ---- randomized run against the model ----
        mem_salt = $urandom;
        rst_n = 1'b0;
        cyc();
        for (int k = 0; k < 3000; k++) begin
            rst_n      = ($urandom_range(0, 199) != 0);
            src        = ($urandom_range(0, 19) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
            tgt_jump   = $urandom;
            tgt_branch = $urandom;
            tgt_reg    = $urandom;
            en         = ($urandom_range(0, 9) < 8);
            ready      = ($urandom_range(0, 9) < 6);
            cyc();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
